mem_wb_stage: RTL and testbench

MEM/WB pipeline register and write-back stage of the five-stage pipeline. It captures the memory-stage result at each clock edge and holds it for one cycle. It extracts and sign/zero-extends load data from the raw data-RAM word and selects the write-back source. It drives the register file's write port (we, wR, wD) directly and exports a retired-instruction counter.

---
 rtl/mem_wb_stage_if.sv | 30 +++
 rtl/mem_wb_stage.sv | 96 +++++++++
 tb/tb_mem_wb_stage.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// MEM-to-WB bundle: memory-stage instruction fields in, register-file write port and trace out.
interface mem_wb_stage_if #(parameter int unsigned XLEN = 32);
  logic            mem_valid;
  logic            mem_we;
  logic [4:0]      mem_wR;
  logic [1:0]      mem_wb_sel;
  logic [2:0]      mem_ld_type;
  logic [XLEN-1:0] mem_alu_c;
  logic [XLEN-1:0] mem_dram;
  logic [XLEN-1:0] mem_pc;
  logic [XLEN-1:0] mem_imm;

  logic            wb_we;
  logic [4:0]      wb_wR;
  logic [XLEN-1:0] wb_wD;
  logic            wb_valid;
  logic [XLEN-1:0] wb_pc;

  modport master (
    output mem_valid, mem_we, mem_wR, mem_wb_sel, mem_ld_type,
           mem_alu_c, mem_dram, mem_pc, mem_imm,
    input  wb_we, wb_wR, wb_wD, wb_valid, wb_pc
  );

  modport slave (
    input  mem_valid, mem_we, mem_wR, mem_wb_sel, mem_ld_type,
           mem_alu_c, mem_dram, mem_pc, mem_imm,
    output wb_we, wb_wR, wb_wD, wb_valid, wb_pc
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register plus write-back mux: load extraction, source select,
// register-file write port and retired-instruction counter.
module mem_wb_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  mem_wb_stage_if.slave   bus,
  output logic [XLEN-1:0] retire_cnt
);

  localparam logic [1:0] SelAlu  = 2'b00;
  localparam logic [1:0] SelLoad = 2'b01;
  localparam logic [1:0] SelPc4  = 2'b10;
  localparam logic [1:0] SelImm  = 2'b11;

  localparam logic [2:0] LdB  = 3'b000;
  localparam logic [2:0] LdH  = 3'b001;
  localparam logic [2:0] LdBu = 3'b100;
  localparam logic [2:0] LdHu = 3'b101;

  logic            validQ;
  logic            weQ;
  logic [4:0]      wRQ;
  logic [1:0]      wbSelQ;
  logic [2:0]      ldTypeQ;
  logic [XLEN-1:0] aluCQ;
  logic [XLEN-1:0] dramQ;
  logic [XLEN-1:0] pcQ;
  logic [XLEN-1:0] immQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validQ     <= 1'b0;
      weQ        <= 1'b0;
      wRQ        <= '0;
      wbSelQ     <= '0;
      ldTypeQ    <= '0;
      aluCQ      <= '0;
      dramQ      <= '0;
      pcQ        <= '0;
      immQ       <= '0;
      retire_cnt <= '0;
    end else if (flush) begin
      // Only valid is cleared; the remaining fields are dead once valid drops.
      validQ <= 1'b0;
    end else if (!stall) begin
      validQ  <= bus.mem_valid;
      weQ     <= bus.mem_we;
      wRQ     <= bus.mem_wR;
      wbSelQ  <= bus.mem_wb_sel;
      ldTypeQ <= bus.mem_ld_type;
      aluCQ   <= bus.mem_alu_c;
      dramQ   <= bus.mem_dram;
      pcQ     <= bus.mem_pc;
      immQ    <= bus.mem_imm;
      if (bus.mem_valid) retire_cnt <= retire_cnt + 1'b1;
    end
  end

  logic [XLEN-1:0] dramShifted;
  logic [7:0]      loadByte;
  logic [15:0]     loadHalf;
  logic [XLEN-1:0] loadData;

  always_comb begin
    dramShifted = dramQ >> {aluCQ[1:0], 3'b000};
    loadByte    = dramShifted[7:0];
    loadHalf    = aluCQ[1] ? dramQ[31:16] : dramQ[15:0];
    case (ldTypeQ)
      LdB:     loadData = {{(XLEN-8){loadByte[7]}}, loadByte};
      LdH:     loadData = {{(XLEN-16){loadHalf[15]}}, loadHalf};
      LdBu:    loadData = {{(XLEN-8){1'b0}}, loadByte};
      LdHu:    loadData = {{(XLEN-16){1'b0}}, loadHalf};
      default: loadData = dramQ;
    endcase
  end

  always_comb begin
    case (wbSelQ)
      SelAlu:  bus.wb_wD = aluCQ;
      SelLoad: bus.wb_wD = loadData;
      SelPc4:  bus.wb_wD = pcQ + 32'd4;
      SelImm:  bus.wb_wD = immQ;
      default: bus.wb_wD = aluCQ;
    endcase
  end

  assign bus.wb_we    = validQ & weQ & (wRQ != 5'd0);
  assign bus.wb_wR    = wRQ;
  assign bus.wb_valid = validQ;
  assign bus.wb_pc    = pcQ;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with hand-computed expected write-back values.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] retire_cnt;

  int unsigned passCnt  = 0;
  int unsigned checkCnt = 0;

  mem_wb_stage_if #(.XLEN(32)) bus ();

  mem_wb_stage #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .flush      (flush),
    .bus        (bus.slave),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] wR,
                       input logic [1:0] sel, input logic [2:0] ld,
                       input logic [31:0] alu, input logic [31:0] dram,
                       input logic [31:0] pc, input logic [31:0] imm);
    bus.mem_valid   = v;
    bus.mem_we      = we;
    bus.mem_wR      = wR;
    bus.mem_wb_sel  = sel;
    bus.mem_ld_type = ld;
    bus.mem_alu_c   = alu;
    bus.mem_dram    = dram;
    bus.mem_pc      = pc;
    bus.mem_imm     = imm;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One load through the pipeline register, checked a cycle later.
  task automatic load(input string tag, input logic [2:0] ld, input logic [1:0] off,
                      input logic [31:0] exp);
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd7, 2'b01, ld, {30'd0, off}, 32'h80F1_7F22, 32'h200, 32'd0);
    step();
    chk(tag, bus.wb_wD, exp);
  endtask

  initial begin
    drive(1'b1, 1'b1, 5'd9, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'd0, 32'h40, 32'd0);
    #12;
    chk("reset_we",     {31'd0, bus.wb_we},    32'd0);
    chk("reset_wR",     {27'd0, bus.wb_wR},    32'd0);
    chk("reset_wD",     bus.wb_wD,             32'd0);
    chk("reset_valid",  {31'd0, bus.wb_valid}, 32'd0);
    chk("reset_pc",     bus.wb_pc,             32'd0);
    chk("reset_retire", retire_cnt,            32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 5'd5, 2'b00, 3'b010, 32'h1234_5678, 32'd0, 32'h100, 32'd0);
    step();
    chk("alu_we",     {31'd0, bus.wb_we},    32'd1);
    chk("alu_wR",     {27'd0, bus.wb_wR},    32'd5);
    chk("alu_wD",     bus.wb_wD,             32'h1234_5678);
    chk("alu_valid",  {31'd0, bus.wb_valid}, 32'd1);
    chk("alu_pc",     bus.wb_pc,             32'h100);
    chk("alu_retire", retire_cnt,            32'd1);

    @(negedge clk);
    drive(1'b1, 1'b1, 5'd0, 2'b00, 3'b010, 32'h1234_5678, 32'd0, 32'h104, 32'd0);
    step();
    chk("x0_we",     {31'd0, bus.wb_we}, 32'd0);
    chk("x0_retire", retire_cnt,         32'd2);

    load("lb_off3",   3'b000, 2'd3, 32'hFFFF_FF80);
    load("lbu_off1",  3'b100, 2'd1, 32'h0000_007F);
    load("lh_off2",   3'b001, 2'd2, 32'hFFFF_80F1);
    load("lhu_off0",  3'b101, 2'd0, 32'h0000_7F22);
    load("lw_off2",   3'b010, 2'd2, 32'h80F1_7F22);
    load("lb_off0",   3'b000, 2'd0, 32'h0000_0022);
    load("lhu_off3",  3'b101, 2'd3, 32'h0000_80F1);
    load("lh_off1",   3'b001, 2'd1, 32'h0000_7F22);
    load("ld_undef",  3'b011, 2'd1, 32'h80F1_7F22);
    chk("load_retire", retire_cnt, 32'd11);

    @(negedge clk);
    drive(1'b1, 1'b1, 5'd1, 2'b10, 3'b000, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd0);
    step();
    chk("pc4_wrap", bus.wb_wD, 32'd0);

    @(negedge clk);
    drive(1'b1, 1'b1, 5'd3, 2'b11, 3'b000, 32'h55, 32'd0, 32'h300, 32'hABCD_E000);
    step();
    chk("imm_wD",     bus.wb_wD,  32'hABCD_E000);
    chk("imm_retire", retire_cnt, 32'd13);

    // Stall three cycles while the MEM side keeps changing.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall = 1'b1;
      drive(1'b1, 1'b1, 5'(10 + i), 2'b00, 3'b000, 32'(i) + 32'h9000, 32'd0, 32'h400, 32'd0);
      step();
      chk("stall_wD",     bus.wb_wD,          32'hABCD_E000);
      chk("stall_we",     {31'd0, bus.wb_we}, 32'd1);
      chk("stall_wR",     {27'd0, bus.wb_wR}, 32'd3);
      chk("stall_pc",     bus.wb_pc,          32'h300);
      chk("stall_retire", retire_cnt,         32'd13);
    end

    @(negedge clk);
    flush = 1'b1;
    step();
    chk("flushstall_valid",  {31'd0, bus.wb_valid}, 32'd0);
    chk("flushstall_we",     {31'd0, bus.wb_we},    32'd0);
    chk("flushstall_retire", retire_cnt,            32'd13);

    @(negedge clk);
    stall = 1'b0;
    step();
    chk("flush_valid",  {31'd0, bus.wb_valid}, 32'd0);
    chk("flush_retire", retire_cnt,            32'd13);

    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 1'b1, 5'd5, 2'b00, 3'b000, 32'h77, 32'd0, 32'h500, 32'd0);
    step();
    chk("bubble_we",     {31'd0, bus.wb_we}, 32'd0);
    chk("bubble_retire", retire_cnt,         32'd13);

    // Asynchronous reset between clock edges with a live instruction in WB.
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd6, 2'b00, 3'b000, 32'h66, 32'd0, 32'h600, 32'd0);
    step();
    chk("pre_reset_we", {31'd0, bus.wb_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_we",     {31'd0, bus.wb_we},    32'd0);
    chk("async_valid",  {31'd0, bus.wb_valid}, 32'd0);
    chk("async_retire", retire_cnt,            32'd0);
    chk("async_wD",     bus.wb_wD,             32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b1;
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1 release dut.retire_cnt;
    #1 chk("wrap_preset", retire_cnt, 32'hFFFF_FFFF);
    @(negedge clk);
    stall = 1'b0;
    drive(1'b1, 1'b1, 5'd2, 2'b00, 3'b000, 32'h1, 32'd0, 32'h700, 32'd0);
    step();
    chk("wrap_retire", retire_cnt, 32'd0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
